// File: rtl/if_stage.sv
// Fetch stage: F-stage PC, next-PC select, IF/ID register, perf counters.
// Optional fetch-address check enabled by defining IF_FETCH_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8,
  output logic        D_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic        fetch_err
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

`ifdef IF_FETCH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [32:0] LIMIT =
    {1'b0, IMEM_BASE} + 33'(4 * IMEM_WORDS);

  if_id_t      d_q;
  if_id_t      d_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_sel;
  logic [31:0] pc_nxt;
  logic [31:0] fcnt_q;
  logic [31:0] scnt_q;
  logic        err_q;
  logic        bad;

  always_comb begin
    pc_sel = pc_q + 32'd4;
    unique case (1'b1)
      branch:  pc_sel = npc;
      default: pc_sel = pc_q + 32'd4;
    endcase
  end

  // Misaligned or outside [IMEM_BASE, IMEM_BASE+4*IMEM_WORDS)
  assign bad = (pc_sel[1:0] != 2'b00)
             || (pc_sel < IMEM_BASE)
             || ({1'b0, pc_sel} >= LIMIT);

  always_comb begin
    pc_nxt = pc_sel;
    if (CHK && bad)
      pc_nxt = RESET_PC;
  end

  always_comb begin
    d_nxt.pc    = pc_q;
    d_nxt.instr = flush ? 32'h0 : imem_rdata;
    d_nxt.valid = ~flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      d_q    <= '0;
      fcnt_q <= '0;
      scnt_q <= '0;
      err_q  <= 1'b0;
    end else if (stall) begin
      scnt_q <= scnt_q + 32'd1;
    end else begin
      pc_q <= pc_nxt;
      d_q  <= d_nxt;
      if (!flush)
        fcnt_q <= fcnt_q + 32'd1;
      if (CHK && bad)
        err_q <= 1'b1;
    end
  end

  assign imem_addr = pc_q;
  assign F_pc      = pc_q;
  assign D_instr   = d_q.instr;
  assign D_pc      = d_q.pc;
  assign D_pc8     = d_q.pc + 32'd8;
  assign D_valid   = d_q.valid;
  assign fetch_cnt = fcnt_q;
  assign stall_cnt = scnt_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed plan plus random traffic vs. a model.
// Honours IF_FETCH_CHECK_EN to pick expectations.
module tb_if_stage;

`ifdef IF_FETCH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] npc = '0;
  logic        flush = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] F_pc;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc8;
  logic        D_valid;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch(branch), .npc(npc), .flush(flush),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .F_pc(F_pc), .D_instr(D_instr), .D_pc(D_pc),
    .D_pc8(D_pc8), .D_valid(D_valid),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
    .fetch_err(fetch_err)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state from the fetch rules
  bit          m_known = 0;
  longint      m_pc;
  longint      m_dpc;
  logic [31:0] m_instr;
  bit          m_dv;
  longint      m_fc;
  longint      m_sc;
  bit          m_err;

  always @(posedge clk) begin
    longint nxt;
    if (reset) begin
      m_known = 1;
      m_pc = 64'h3000; m_dpc = 0; m_instr = 0; m_dv = 0;
      m_fc = 0; m_sc = 0; m_err = 0;
    end else if (m_known) begin
      if (stall) begin
        m_sc = (m_sc + 1) % (64'd1 << 32);
      end else begin
        nxt = branch ? longint'(npc)
                     : (m_pc + 4) % (64'd1 << 32);
        m_dpc = m_pc;
        m_instr = flush ? 32'h0 : imem_word(32'(m_pc));
        m_dv = !flush;
        if (!flush) m_fc = (m_fc + 1) % (64'd1 << 32);
        if (CHK && (nxt % 4 != 0 || nxt < 64'h3000
                    || nxt >= 64'h3000 + 4 * 4096)) begin
          m_err = 1;
          nxt = 64'h3000;
        end
        m_pc = nxt;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("F_pc", F_pc, 32'(m_pc));
      chk("imem_addr", imem_addr, 32'(m_pc));
      chk("D_pc", D_pc, 32'(m_dpc));
      chk("D_pc8", D_pc8, 32'((m_dpc + 8) % (64'd1 << 32)));
      chk("D_instr", D_instr, m_instr);
      chk("D_valid", {31'b0, D_valid}, {31'b0, m_dv});
      chk("fetch_cnt", fetch_cnt, 32'(m_fc));
      chk("stall_cnt", stall_cnt, 32'(m_sc));
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    end
  end

  task automatic cyc(input logic r, input logic s,
                     input logic b, input logic [31:0] n,
                     input logic f);
    reset = r; stall = s; branch = b; npc = n; flush = f;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("lit_rst_pc", F_pc, 32'h3000);
    chk("lit_rst_valid", {31'b0, D_valid}, 32'h0);
    chk("lit_rst_fcnt", fetch_cnt, 32'h0);

    cyc(0, 0, 0, 0, 0);
    chk("lit_dpc0", D_pc, 32'h3000);
    chk("lit_dinstr0", D_instr, imem_word(32'h3000));
    cyc(0, 0, 0, 0, 0);
    chk("lit_pc_3008", F_pc, 32'h3008);

    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("lit_stall_pc", F_pc, 32'h3008);
    chk("lit_stall_dpc", D_pc, 32'h3004);
    chk("lit_stall_cnt", stall_cnt, 32'd2);
    cyc(0, 0, 0, 0, 0);
    chk("lit_release_pc", F_pc, 32'h300C);
    chk("lit_fcnt3", fetch_cnt, 32'd3);
    cyc(0, 0, 0, 0, 0);

    cyc(0, 0, 1, 32'h3040, 0);
    chk("lit_br_pc", F_pc, 32'h3040);
    chk("lit_br_dpc", D_pc, 32'h3010);
    chk("lit_br_dpc8", D_pc8, 32'h3018);

    cyc(0, 0, 1, 32'h3100, 1);
    chk("lit_fl_pc", F_pc, 32'h3100);
    chk("lit_fl_instr", D_instr, 32'h0);
    chk("lit_fl_valid", {31'b0, D_valid}, 32'h0);
    chk("lit_fl_fcnt", fetch_cnt, 32'd5);

    cyc(0, 1, 1, 32'h3200, 0);
    chk("lit_stbr_pc", F_pc, 32'h3100);
    cyc(0, 0, 1, 32'h3200, 0);
    chk("lit_stbr_pc2", F_pc, 32'h3200);

    cyc(0, 0, 1, 32'h3002, 0);
    chk("lit_mis_pc", F_pc, CHK ? 32'h3000 : 32'h3002);
    chk("lit_mis_err", {31'b0, fetch_err}, {31'b0, CHK});
    cyc(0, 0, 0, 0, 0);
    chk("lit_err_sticky", {31'b0, fetch_err}, {31'b0, CHK});

    cyc(1, 1, 1, 32'h5000, 1);
    chk("lit_rst2_err", {31'b0, fetch_err}, 32'h0);
    chk("lit_rst2_pc", F_pc, 32'h3000);
    cyc(0, 0, 1, 32'h0, 0);
    chk("lit_zero_pc", F_pc, CHK ? 32'h3000 : 32'h0);
    chk("lit_zero_err", {31'b0, fetch_err}, {31'b0, CHK});

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_wrap_pc", F_pc, CHK ? 32'h3004 : 32'h0);
    chk("lit_wrap_dpc8", D_pc8, CHK ? 32'h3008 : 32'h4);

    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, b, f;
      logic [31:0] n;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 9) < 8)
        n = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      else
        n = $urandom;
      cyc(r, s, b, n, f);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
